// File: rtl/fetch_pc_if.sv
// Instruction-memory request bus between the IF-stage PC generator and the
// instruction memory.
//   pc           : fetch address, held stable until the request is accepted
//   ce           : request valid / chip enable
//   misalign_o   : the current request address is not instruction-aligned
//   imem_ready_i : memory accepts the request at pc this cycle
// The master modport belongs to the PC generator and the slave modport to the memory.
interface fetch_pc_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic              misalign_o;
    logic              imem_ready_i;

    modport master (
        output pc,
        output ce,
        output misalign_o,
        input  imem_ready_i
    );

    modport slave (
        input  pc,
        input  ce,
        input  misalign_o,
        output imem_ready_i
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// IF-stage program-counter generator with a ready-handshaked memory request.
// The PC is held while a request waits. A flush or branch that arrives during
// the wait is latched and applied on the cycle the request is accepted.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   stall                   : stall vector from CTRL; only bit 0 (hold IF) is used
//   branch_flag_i           : branch taken, from ID
//   branch_target_address_i : branch target, from ID
//   flush                   : exception flush, from CTRL
//   new_pc                  : exception handler entry address
//   imem                    : request bus (pc, ce, misalign_o, imem_ready_i)
//   redirect_pending_o      : a latched redirect is waiting for the accept
module fetch_pc_unit #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h00000000,
    parameter int                INST_BYTES   = 4,
    parameter int                FETCH_N      = 1,
    parameter int                STALL_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  new_pc,
    fetch_pc_if.master         imem,
    output logic               redirect_pending_o
);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(INST_BYTES * FETCH_N);
    localparam int                ALIGN_W = $clog2(INST_BYTES);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q, ce_d;
    logic              pend_valid_q, pend_valid_d;
    logic              pend_flush_q, pend_flush_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

    always_comb begin
        pc_d         = pc_q;
        ce_d         = 1'b1;
        pend_valid_d = pend_valid_q;
        pend_flush_d = pend_flush_q;
        pend_addr_d  = pend_addr_q;

        if (!ce_q) begin
            // This is the first cycle after reset. The first request goes out at the reset vector.
            pc_d         = RESET_VECTOR;
            pend_valid_d = 1'b0;
            pend_flush_d = 1'b0;
        end else if (!imem.imem_ready_i) begin
            // Wait: the request stays stable and redirects are latched.
            // A flush always overwrites an earlier pending entry. A branch never displaces a pending flush.
            if (flush) begin
                pend_valid_d = 1'b1;
                pend_flush_d = 1'b1;
                pend_addr_d  = new_pc;
            end else if (branch_flag_i && !stall[0] && !(pend_valid_q && pend_flush_q)) begin
                pend_valid_d = 1'b1;
                pend_flush_d = 1'b0;
                pend_addr_d  = branch_target_address_i;
            end
        end else begin
            // Accept. A pending redirect overrides the stall and any new branch, because that branch is on the wrong path.
            // A branch under stall is dropped. ID presents it again.
            if (flush) begin
                pc_d = new_pc;
            end else if (pend_valid_q) begin
                pc_d = pend_addr_q;
            end else if (stall[0]) begin
                pc_d = pc_q;
            end else if (branch_flag_i) begin
                pc_d = branch_target_address_i;
            end else begin
                pc_d = pc_q + STEP;
            end
            pend_valid_d = 1'b0;
            pend_flush_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_VECTOR;
            ce_q         <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_flush_q <= 1'b0;
            pend_addr_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            ce_q         <= ce_d;
            pend_valid_q <= pend_valid_d;
            pend_flush_q <= pend_flush_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    assign imem.pc            = pc_q;
    assign imem.ce            = ce_q;
    assign redirect_pending_o = pend_valid_q;

    generate
        if (ALIGN_W == 0) begin : g_no_align
            assign imem.misalign_o = 1'b0;
        end else begin : g_align
            assign imem.misalign_o = ce_q & (|pc_q[ALIGN_W-1:0]);
        end

        if (STALL_W > 1) begin : g_stall_hi
            logic unused_stall_hi;
            assign unused_stall_hi = ^stall[STALL_W-1:1];
        end
    endgenerate
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter generator for the IF stage. It replaces the single-width, zero-wait PC register.
- Parametrised in address width, reset vector and fetch step.
- Drives a ready-handshaked instruction-memory request and holds PC stable while a request is unaccepted.
- Latches exception flushes and branch redirects that arrive during a memory wait and applies them once the wait ends.

Parameters:
ADDR_W, 32, PC / target width in bits
RESET_VECTOR, 32'h00000000, PC value during and immediately after reset
INST_BYTES, 4, bytes per instruction; power of 2, ≥1; sets alignment check
FETCH_N, 1, instructions fetched per request; power of 2; step = INST_BYTES*FETCH_N
STALL_W, 6, width of pipeline stall vector from CTRL (only bit 0 used)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
stall  in  STALL_W  stall vector from CTRL; stall[0]=1 holds IF
branch_flag_i  in  1  ID branch taken
branch_target_address_i  in  ADDR_W  ID branch target
flush  in  1  exception flush from CTRL
new_pc  in  ADDR_W  exception handler entry address
imem_ready_i  in  1  memory accepts the request at pc this cycle
pc  out  ADDR_W  current fetch address (registered)
ce  out  1  fetch request / chip enable (registered)
misalign_o  out  1  ce & (pc mod INST_BYTES ≠ 0); combinational
redirect_pending_o  out  1  a latched redirect is waiting (registered)

Behaviour:
- Reset (rst=1 at posedge):
  - ce←0, pc←RESET_VECTOR, pending cleared, redirect_pending_o←0.
- First cycle after reset:
  - ce←1 registered, so ce rises one cycle after rst falls.
  - While ce=0, pc←RESET_VECTOR and pending stays cleared.
  - The first request is at RESET_VECTOR.
- Definitions:
  - accept = ce & imem_ready_i.
  - wait = ce & ~imem_ready_i.
  - STEP = INST_BYTES*FETCH_N.
- Wait cycle: pc is unchanged (request must stay stable until accepted).
  - flush=1 → pending←{valid, kind=FLUSH, addr=new_pc}. This overwrites any pending entry, including an earlier FLUSH, so the last flush wins.
  - Else branch_flag_i=1 & stall[0]=0 & pending kind≠FLUSH → pending←{valid, kind=BRANCH, addr=branch target}.
  - Else pending is unchanged.
- Accept cycle, priority highest first:
  1. flush=1 → pc←new_pc.
  2. Pending valid → pc←pending addr. This applies regardless of stall[0]; any simultaneous new branch is dropped as a wrong-path branch.
  3. stall[0]=1 → pc held; the same address is re-requested next cycle. A branch in this cycle is ignored, because ID re-presents it.
  4. branch_flag_i=1 → pc←branch target.
  5. Otherwise pc←pc+STEP.
  - Pending is cleared on every accept cycle.
- Arithmetic: pc+STEP is truncated to ADDR_W and wraps modulo 2^ADDR_W with no flag.
- Alignment:
  - No alignment masking is applied to targets.
  - misalign_o is reported for downstream exception logic.
  - Fetch proceeds at the unaligned address.
  - INST_BYTES=1 → misalign_o is constant 0.
- redirect_pending_o equals pending valid.
- Reset mid-wait: pending is discarded and the outstanding request is abandoned (ce←0).
- Latency: a redirect on an accept cycle appears on pc the next cycle. A redirect arriving during wait appears the cycle after the accepting cycle.

Test Plan:
1. rst high 3 cycles, then low, imem_ready_i=1, RESET_VECTOR=0 → ce=0 first cycle after rst falls, then 1; pc sequence 0,0,4,8,C.
2. Parameters FETCH_N=2, INST_BYTES=4, ADDR_W=32; pc=32'hFFFFFFF8, accept → pc=0 (wraparound, step 8).
3. pc=0x100, imem_ready_i=0 for 3 cycles; branch to 0x200 in wait cycle 1; ready=1 in cycle 4 → pc stays 0x100 throughout; redirect_pending_o=1 from cycle 2; pc=0x200 after accept; pending cleared.
4. During wait, branch to 0x200, then flush new_pc=0x180, then another branch to 0x300; then accept → pc=0x180 (flush wins, later branch ignored).
5. Accept with stall[0]=1 and branch_flag_i=1 (target 0x40) at pc=0x20 → pc stays 0x20, branch dropped; next cycle stall[0]=0, no branch → pc=0x24.
6. Branch target 0x102 with INST_BYTES=4 → pc=0x102, misalign_o=1 while ce=1; rst asserted mid-wait with pending set → pc=RESET_VECTOR, ce=0, redirect_pending_o=0 next cycle.
